// File: rtl/instr_sequencer.sv
// Instruction sequencer: a circular FIFO of 16-bit instruction words feeding
// a downstream processor one word at a time through a Run/Done handshake.
module instr_sequencer #(
    parameter int DEPTH = 8
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        Load,
    input  logic [15:0] LoadData,
    input  logic        Start,
    input  logic        Halt,
    input  logic        Done,
    output logic [15:0] Instruction,
    output logic        Run,
    output logic        Busy,
    output logic        Full,
    output logic        Empty,
    output logic [4:0]  Count,
    output logic [7:0]  Issued,
    output logic [1:0]  DbgState
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_e;

    // Handshake: Run is a one-cycle issue strobe with Instruction stable from
    // that cycle until the next issue; Done is only honoured while in WAIT.
    state_e         state_q;
    logic           run_q;
    logic [15:0]    instr_q;
    logic [7:0]     issued_q;
    logic [4:0]     count_q, count_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [15:0]    mem_q [DEPTH];

    logic full, empty, push, pop;

    always_comb begin
        full     = (count_q == 5'(DEPTH));
        empty    = (count_q == 5'd0);
        // Full is judged on the registered count, so a slot freed by a
        // same-cycle pop cannot be claimed by a Load in that cycle.
        push     = Load & ~full;
        pop      = ((state_q == IDLE) & Start & ~empty) |
                   ((state_q == WAIT) & Done & ~Halt & ~empty);
        count_d  = count_q + 5'(push) - 5'(pop);
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    end

    always_ff @(posedge Clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= LoadData;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q  <= IDLE;
            run_q    <= 1'b0;
            instr_q  <= 16'h0000;
            issued_q <= 8'd0;
            count_q  <= 5'd0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            run_q    <= 1'b0;
            if (pop) begin
                instr_q <= mem_q[rd_ptr_q];
            end
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        state_q <= ISSUE;
                        run_q   <= 1'b1;
                    end
                end
                ISSUE: begin
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (Done) begin
                        issued_q <= issued_q + 8'd1;
                        if (pop) begin
                            state_q <= ISSUE;
                            run_q   <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign Instruction = instr_q;
    assign Run         = run_q;
    assign Busy        = (state_q != IDLE);
    assign Full        = full;
    assign Empty       = empty;
    assign Count       = count_q;
    assign Issued      = issued_q;
    assign DbgState    = state_q;

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 Parameter DEPTH, default 8, instruction buffer entries (power of two, 2..16).
REQ-002 Clock  in  1  single system clock; all state updates on rising edge.
REQ-003 Resetn  in  1  asynchronous, active-low reset.
REQ-004 Load  in  1  write strobe; pushes LoadData into buffer.
REQ-005 LoadData  in  16  instruction word to buffer.
REQ-006 Start  in  1  begin issuing buffered instructions.
REQ-007 Halt  in  1  stop issuing after the in-flight instruction completes.
REQ-008 Done  in  1  completion flag from downstream processor.
REQ-009 Instruction  out  16  registered instruction word to processor.
REQ-010 Run  out  1  one-cycle issue strobe to processor.
REQ-011 Busy  out  1  high in any state other than IDLE.
REQ-012 Full  out  1  buffer holds DEPTH entries.
REQ-013 Empty  out  1  buffer holds zero entries.
REQ-014 Count  out  5  current buffer occupancy, 0..DEPTH.
REQ-015 Issued  out  8  count of instructions completed since reset.

Function
REQ-016 Buffer SHALL be FIFO, circular, with read/write pointers wrapping modulo DEPTH.
REQ-017 Load with Full=0 SHALL write LoadData at write pointer and increment Count; Load with Full=1 SHALL be ignored, no state change.
REQ-018 Full SHALL be evaluated before any same-cycle pop; a Load in the cycle a pop frees a slot from full SHALL be rejected.
REQ-019 A same-cycle Load and pop with 0<Count<DEPTH SHALL leave Count unchanged, both operations performed.
REQ-020 FSM states: IDLE, ISSUE, WAIT.
REQ-021 IDLE: Run=0; Start=1 and Empty=0 -> ISSUE, popping head into Instruction on that edge; Start=1 with Empty=1 -> remain IDLE.
REQ-022 ISSUE: Run=1 for exactly one cycle, Instruction stable; unconditional -> WAIT; Done in ISSUE SHALL be ignored.
REQ-023 WAIT: Run=0, Instruction held; on edge with Done=1: Issued increments (wraps 255->0); then if Halt=0 and Empty=0 -> ISSUE with next head popped into Instruction, else -> IDLE.
REQ-024 Halt SHALL have no effect in IDLE or ISSUE other than being sampled at the WAIT exit edge; a Halted sequence resumes on a later Start.
REQ-025 Consecutive instructions SHALL be separated by at least one Run=0 cycle (minimum: Done edge -> ISSUE next cycle).
REQ-026 Instruction SHALL change only on the edge entering ISSUE.
REQ-027 Loads SHALL be accepted in every FSM state; an instruction loaded during WAIT into an empty buffer SHALL issue after the current Done.
REQ-028 Busy, Full, Empty, Count SHALL be derived from registered state only (no combinational path from inputs).

Reset
REQ-029 Resetn=0 SHALL immediately force: state IDLE, Run=0, Busy=0, Instruction=16'h0000, Count=0, Empty=1, Full=0, Issued=0, both pointers 0.
REQ-030 Reset mid-operation (ISSUE or WAIT) SHALL discard buffered and in-flight instructions; no Run pulse after release until a new Start.
REQ-031 Buffer storage contents need not be cleared by reset.

Verification
REQ-032 Load 16'h101C, 16'h32FF, 16'h52FF; pulse Start; Done returned 3 cycles after each Run -> three single-cycle Run pulses with Instruction 16'h101C, 16'h32FF, 16'h52FF in order, Issued=3, Busy=0, Empty=1 at end.
REQ-033 Load 9 words with DEPTH=8 and no Start -> Full=1, Count=8, 9th word dropped; drain shows first 8 words only.
REQ-034 Start with Empty=1 -> Run stays 0, Busy stays 0.
REQ-035 Load 4 words, Start, assert Halt during 2nd WAIT -> exactly 2 Runs, IDLE, Count=2; new Start issues words 3 and 4.
REQ-036 Hold Done=1 continuously through ISSUE -> Issued increments only at the WAIT edge, once per Run.
REQ-037 Assert Resetn=0 during WAIT with Count=3 -> Run=0, Count=0, Instruction=16'h0000, Issued=0 asynchronously; no Run after release without Start.
